// File: rtl/seg_execute_alu_control.sv
// Execute-stage ALU control decoder: ALUOp/funct/opcode -> registered 4-bit ALU code.
// Optional build macro ALUCTL_BYPASS_EN adds i_bypass for a combinational (0-cycle) output path.
module seg_execute_alu_control #(
  parameter int NB_ALUCTL = 4,
  parameter int NB_FUNCT  = 6,
  parameter int NB_ALUOP  = 2,
  parameter int NB_CNT    = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  input  logic [NB_ALUOP-1:0]  i_ALUOp,
  input  logic [NB_FUNCT-1:0]  i_funct,
  input  logic [NB_FUNCT-1:0]  i_opcode,
  input  logic                 i_stall,
  input  logic                 i_flush,
`ifdef ALUCTL_BYPASS_EN
  input  logic                 i_bypass,
`endif
  output logic [NB_ALUCTL-1:0] o_ALUctl,
  output logic                 o_valid,
  output logic                 o_illegal,
  output logic [NB_CNT-1:0]    o_illegal_cnt
);

  localparam logic [NB_ALUCTL-1:0] CTL_AND  = NB_ALUCTL'(4'b0000);
  localparam logic [NB_ALUCTL-1:0] CTL_OR   = NB_ALUCTL'(4'b0001);
  localparam logic [NB_ALUCTL-1:0] CTL_ADD  = NB_ALUCTL'(4'b0010);
  localparam logic [NB_ALUCTL-1:0] CTL_XOR  = NB_ALUCTL'(4'b0011);
  localparam logic [NB_ALUCTL-1:0] CTL_SUB  = NB_ALUCTL'(4'b0110);
  localparam logic [NB_ALUCTL-1:0] CTL_SLT  = NB_ALUCTL'(4'b0111);
  localparam logic [NB_ALUCTL-1:0] CTL_SLTU = NB_ALUCTL'(4'b1000);
  localparam logic [NB_ALUCTL-1:0] CTL_NOR  = NB_ALUCTL'(4'b1100);
  localparam logic [NB_ALUCTL-1:0] CTL_LUI  = NB_ALUCTL'(4'b1101);

  logic [NB_ALUCTL-1:0] dec_ctl;
  logic                 dec_illegal;

  logic [NB_ALUCTL-1:0] ctl_q, ctl_d;
  logic                 valid_q, valid_d;
  logic                 illegal_q, illegal_d;
  logic [NB_CNT-1:0]    cnt_q, cnt_d;

  // Unsupported encodings fall back to ADD so the ALU still sees a harmless code.
  always_comb begin
    dec_ctl     = CTL_ADD;
    dec_illegal = 1'b0;
    case (i_ALUOp)
      2'b00: dec_ctl = CTL_ADD;
      2'b01: dec_ctl = CTL_SUB;
      2'b10: begin
        case (i_funct)
          6'b100000, 6'b100001: dec_ctl = CTL_ADD;
          6'b100010, 6'b100011: dec_ctl = CTL_SUB;
          6'b100100:            dec_ctl = CTL_AND;
          6'b100101:            dec_ctl = CTL_OR;
          6'b100110:            dec_ctl = CTL_XOR;
          6'b100111:            dec_ctl = CTL_NOR;
          6'b101010:            dec_ctl = CTL_SLT;
          6'b101011:            dec_ctl = CTL_SLTU;
          default:              dec_illegal = 1'b1;
        endcase
      end
      default: begin
        case (i_opcode)
          6'b001000, 6'b001001: dec_ctl = CTL_ADD;
          6'b001100:            dec_ctl = CTL_AND;
          6'b001101:            dec_ctl = CTL_OR;
          6'b001110:            dec_ctl = CTL_XOR;
          6'b001010:            dec_ctl = CTL_SLT;
          6'b001011:            dec_ctl = CTL_SLTU;
          6'b001111:            dec_ctl = CTL_LUI;
          default:              dec_illegal = 1'b1;
        endcase
      end
    endcase
  end

  // Flush beats stall; the counter survives flush and only moves on a real load.
  always_comb begin
    ctl_d     = ctl_q;
    valid_d   = valid_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    if (i_flush) begin
      ctl_d     = CTL_ADD;
      valid_d   = 1'b0;
      illegal_d = 1'b0;
    end else if (!i_stall) begin
      ctl_d     = dec_ctl;
      valid_d   = i_valid;
      illegal_d = dec_illegal & i_valid;
      if (dec_illegal && i_valid && (cnt_q != {NB_CNT{1'b1}}))
        cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ctl_q     <= CTL_ADD;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      ctl_q     <= ctl_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef ALUCTL_BYPASS_EN
  assign o_ALUctl  = i_bypass ? dec_ctl : ctl_q;
  assign o_valid   = i_bypass ? i_valid : valid_q;
  assign o_illegal = i_bypass ? (dec_illegal & i_valid) : illegal_q;
`else
  assign o_ALUctl  = ctl_q;
  assign o_valid   = valid_q;
  assign o_illegal = illegal_q;
`endif
  assign o_illegal_cnt = cnt_q;

endmodule

// File: tb/tb_seg_execute_alu_control.sv
// Directed bench for seg_execute_alu_control: main instance plus a 2-bit-counter instance for saturation.
module tb_seg_execute_alu_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid;
  logic [1:0] aluop;
  logic [5:0] funct;
  logic [5:0] opcode;
  logic       stall;
  logic       flush;

  logic [3:0] ctl, ctl2;
  logic       vld, vld2;
  logic       ill, ill2;
  logic [7:0] cnt;
  logic [1:0] cnt2;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  seg_execute_alu_control dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_ALUOp(aluop),
    .i_funct(funct), .i_opcode(opcode), .i_stall(stall), .i_flush(flush),
    .o_ALUctl(ctl), .o_valid(vld), .o_illegal(ill), .o_illegal_cnt(cnt)
  );

  seg_execute_alu_control #(.NB_CNT(2)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_ALUOp(aluop),
    .i_funct(funct), .i_opcode(opcode), .i_stall(stall), .i_flush(flush),
    .o_ALUctl(ctl2), .o_valid(vld2), .o_illegal(ill2), .o_illegal_cnt(cnt2)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [1:0] op, input logic [5:0] f, input logic [5:0] oc);
    valid  = v;
    aluop  = op;
    funct  = f;
    opcode = oc;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    set_in(1'b1, 2'b10, 6'b100100, 6'b0);
    step(); step();
    chk("rst_ctl", {4'h0, ctl}, 8'h02);
    chk("rst_vld", {7'h0, vld}, 8'h00);
    chk("rst_ill", {7'h0, ill}, 8'h00);
    chk("rst_cnt", cnt, 8'h00);
    rst_n = 1'b1;

    // R-type sweep
    set_in(1'b1, 2'b10, 6'b100010, 6'b0); step();
    chk("r_sub", {4'h0, ctl}, 8'h06);
    chk("r_sub_vld", {7'h0, vld}, 8'h01);
    set_in(1'b1, 2'b10, 6'b100100, 6'b0); step();
    chk("r_and", {4'h0, ctl}, 8'h00);
    set_in(1'b1, 2'b10, 6'b100111, 6'b0); step();
    chk("r_nor", {4'h0, ctl}, 8'h0C);
    set_in(1'b1, 2'b10, 6'b101011, 6'b0); step();
    chk("r_sltu", {4'h0, ctl}, 8'h08);
    chk("r_sltu_vld", {7'h0, vld}, 8'h01);
    chk("r_sltu_ill", {7'h0, ill}, 8'h00);

    // Immediate / branch / load-store
    set_in(1'b1, 2'b11, 6'b0, 6'b001111); step();
    chk("i_lui", {4'h0, ctl}, 8'h0D);
    set_in(1'b1, 2'b01, 6'b100100, 6'b0); step();
    chk("br_sub", {4'h0, ctl}, 8'h06);
    set_in(1'b1, 2'b00, 6'b100100, 6'b001101); step();
    chk("ls_add", {4'h0, ctl}, 8'h02);
    set_in(1'b1, 2'b11, 6'b0, 6'b001110); step();
    chk("i_xor", {4'h0, ctl}, 8'h03);

    // Stall holds, flush wins over stall
    set_in(1'b1, 2'b11, 6'b0, 6'b001010); step();
    chk("i_slt", {4'h0, ctl}, 8'h07);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in(1'(i), 2'b10, 6'(32 + i), 6'b0);
      step();
      chk("stall_ctl", {4'h0, ctl}, 8'h07);
      chk("stall_vld", {7'h0, vld}, 8'h01);
    end
    flush = 1'b1; step();
    chk("flush_ctl", {4'h0, ctl}, 8'h02);
    chk("flush_vld", {7'h0, vld}, 8'h00);
    stall = 1'b0; flush = 1'b0;

    // Illegal encodings and counting
    set_in(1'b1, 2'b10, 6'b111111, 6'b0); step();
    chk("ill_flag", {7'h0, ill}, 8'h01);
    chk("ill_ctl", {4'h0, ctl}, 8'h02);
    chk("ill_vld", {7'h0, vld}, 8'h01);
    chk("ill_cnt1", cnt, 8'h01);
    set_in(1'b0, 2'b10, 6'b111111, 6'b0); step();
    chk("ill_bub_flag", {7'h0, ill}, 8'h00);
    chk("ill_bub_cnt", cnt, 8'h01);
    set_in(1'b1, 2'b11, 6'b0, 6'b000000); step();
    chk("ill_imm_flag", {7'h0, ill}, 8'h01);
    chk("ill_cnt2", cnt, 8'h02);
    chk("sat_cnt2", {6'h0, cnt2}, 8'h02);
    set_in(1'b1, 2'b10, 6'b111111, 6'b0);
    for (int i = 0; i < 3; i++) step();
    chk("ill_cnt5", cnt, 8'h05);
    chk("sat_cnt3", {6'h0, cnt2}, 8'h03);
    stall = 1'b1; step();
    chk("stall_cnt", cnt, 8'h05);
    stall = 1'b0; flush = 1'b1; step();
    chk("flush_cnt", cnt, 8'h05);
    chk("flush_sat", {6'h0, cnt2}, 8'h03);
    chk("flush_ill", {7'h0, ill}, 8'h00);
    flush = 1'b0;

    // Bubble still loads the decode
    set_in(1'b0, 2'b10, 6'b100101, 6'b0); step();
    chk("bub_ctl", {4'h0, ctl}, 8'h01);
    chk("bub_vld", {7'h0, vld}, 8'h00);

    // Asynchronous reset mid-stream
    set_in(1'b1, 2'b10, 6'b100010, 6'b0); step();
    chk("pre_rst_vld", {7'h0, vld}, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ctl", {4'h0, ctl}, 8'h02);
    chk("arst_vld", {7'h0, vld}, 8'h00);
    chk("arst_cnt", cnt, 8'h00);
    chk("arst_sat", {6'h0, cnt2}, 8'h00);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_ctl", {4'h0, ctl}, 8'h06);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
